// File: rtl/buffer16_reader.sv
// Snapshots a 16x16 byte tile on start and streams it as 64 four-byte beats
// over a valid/ready handshake, flagging the final beat with last and done.
module buffer16_lane #(
    parameter int LANE = 0
) (
    input  logic [0:15][7:0] row,
    input  logic [1:0]       quad,
    output logic [7:0]       byte_o
);
    // Lane L of quad q picks column 4q + L out of the selected row.
    logic [3:0] col;
    assign col    = {quad, 2'(LANE)};
    assign byte_o = row[col];
endmodule

module buffer16_reader (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [0:15][0:15][7:0]      in,
    input  logic                        ready,
    output logic                        valid,
    output logic [0:3][7:0]             out,
    output logic [5:0]                  index,
    output logic                        last,
    output logic                        busy,
    output logic                        done
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]                 state;
    logic [5:0]                 idx;
    logic                       done_q;
    logic [0:15][0:15][7:0]     snap;
    logic [0:15][VEC_W-1:0]     row;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 6'd0;
            done_q <= 1'b0;
            snap   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= in;
                        idx   <= 6'd0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (ready) begin
                        // Index stays at 63 after the final beat so the last beat remains observable.
                        if (idx == 6'd63) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign row = snap[idx[5:2]];

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            buffer16_lane #(.LANE(g)) u_lane (
                .row    (row),
                .quad   (idx[1:0]),
                .byte_o (lane_byte[g])
            );
            assign out[g] = lane_byte[g];
        end
    endgenerate

    assign valid = (state == STREAM);
    assign busy  = (state == STREAM);
    assign last  = valid && (idx == 6'd63);
    assign index = idx;
    assign done  = done_q;
endmodule

// File: tb/tb_buffer16_reader.sv
// Randomized self-checking bench for buffer16_reader against a matrix-level reference model.
module tb_buffer16_reader;
    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [0:15][0:15][7:0] din;
    logic                   ready;
    logic                   valid;
    logic [0:3][7:0]        out;
    logic [5:0]             index;
    logic                   last;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mat [16][16];

    buffer16_reader dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .in    (din),
        .ready (ready),
        .valid (valid),
        .out   (out),
        .index (index),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_beat(int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = ref_mat[k/4][4*(k%4)+i];
        return r;
    endfunction

    // pattern 0: 16r+c, 1: random, 2: constant 0xAA
    task automatic load_in(input int pattern);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                logic [7:0] v;
                v = (pattern == 0) ? 8'(16*r + c) : (pattern == 1) ? 8'($urandom) : 8'hAA;
                din[r][c] = v;
                ref_mat[r][c] = v;
            end
    endtask

    task automatic start_stream();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || index !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_accept: valid=%0b index=%0d busy=%0b, want 1/0/1", valid, index, busy);
        end
    endtask

    // mode 0: ready=1, 1: alternating, 2: random, 3: ready=1 with mid-stream restart attempt.
    // b2b=1 asserts start with fresh data during the done cycle.
    task automatic run_stream(input int mode, input bit b2b);
        int exp_idx = 0;
        int xfers = 0;
        int cycles = 0;
        logic [31:0] prev_out;
        logic [5:0]  prev_idx;
        bit tog = 1'b1;
        bit finished = 1'b0;
        while (!finished && cycles < 1000) begin
            case (mode)
                1: ready = tog;
                2: ready = 1'($urandom);
                default: ready = 1'b1;
            endcase
            tog = ~tog;
            if (mode == 3 && exp_idx == 10) begin
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) din[r][c] = 8'hAA;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || index !== 6'(exp_idx) || out !== exp_beat(exp_idx)
                || last !== (exp_idx == 63) || done !== 1'b0) begin
                errors++;
                $display("FAIL beat: idx=%0d out=%h last=%0b valid=%0b busy=%0b done=%0b, want idx=%0d out=%h last=%0b",
                         index, out, last, valid, busy, done, exp_idx, exp_beat(exp_idx), exp_idx == 63);
            end
            prev_out = out;
            prev_idx = index;
            step();
            cycles++;
            if (ready) begin
                xfers++;
                if (exp_idx == 63) finished = 1'b1;
                else exp_idx++;
            end else begin
                checks++;
                if (index !== prev_idx || out !== prev_out || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL hold: idx=%0d out=%h valid=%0b, want idx=%0d out=%h valid=1", index, out, valid, prev_idx, prev_out);
                end
            end
        end
        start = 1'b0;
        if (!finished) begin
            errors++;
            $display("FAIL stream_timeout: transfers=%0d, want 64", xfers);
            return;
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 || index !== 6'd63) begin
            errors++;
            $display("FAIL done_cycle: done=%0b valid=%0b busy=%0b last=%0b idx=%0d, want 1/0/0/0/63", done, valid, busy, last, index);
        end
        checks++;
        if (xfers !== 64 || (mode != 2 && mode != 1 && cycles !== 64)) begin
            errors++;
            $display("FAIL transfer_count: xfers=%0d cycles=%0d, want 64", xfers, cycles);
        end
        if (b2b) begin
            load_in(1);
            start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (valid !== 1'b1 || index !== 6'd0 || done !== 1'b0 || out !== exp_beat(0)) begin
                errors++;
                $display("FAIL b2b_start: valid=%0b idx=%0d done=%0b out=%h, want 1/0/0/%h", valid, index, done, out, exp_beat(0));
            end
        end else begin
            step();
            checks++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width: done=%0b valid=%0b, want 0/0", done, valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ready = 1'b0; din = '0;
        step();
        step();
        reset = 1'b0;
        load_in(1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || index !== 6'd0 || out !== 32'd0 || last !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: valid=%0b busy=%0b done=%0b idx=%0d out=%h last=%0b, want all 0",
                         valid, busy, done, index, out, last);
            end
        end
    endtask

    task automatic test_full_rate();
        load_in(0);
        start_stream();
        checks++;
        // spot-check the pattern-derived values independently of the model
        if (out !== 32'h00010203) begin
            errors++;
            $display("FAIL beat0_const: out=%h, want 00010203", out);
        end
        run_stream(0, 1'b0);
        checks++;
        if (out !== 32'hFCFDFEFF) begin
            errors++;
            $display("FAIL beat63_const: out=%h, want fcfdfeff", out);
        end
    endtask

    task automatic test_alternating();
        load_in(0);
        start_stream();
        run_stream(1, 1'b0);
    endtask

    task automatic test_random_ready();
        load_in(1);
        start_stream();
        run_stream(2, 1'b0);
    endtask

    task automatic test_start_ignored();
        load_in(0);
        start_stream();
        run_stream(3, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_in(1);
        start_stream();
        ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (index !== 6'd30) begin
            errors++;
            $display("FAIL pre_reset_idx: idx=%0d, want 30", index);
        end
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || index !== 6'd0 || done !== 1'b0 || out !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b busy=%0b idx=%0d done=%0b out=%h, want 0/0/0/0/0",
                     valid, busy, index, done, out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: done=%0b valid=%0b, want 0/0", done, valid);
            end
        end
        load_in(1);
        start_stream();
        run_stream(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_in(1);
        start_stream();
        run_stream(0, 1'b1);
        run_stream(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_alternating();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer16_reader.md
# buffer16_reader

Read-side counterpart of the 16x16 byte tile buffer: snapshots a full 16x16 matrix of 8-bit values on a start request and streams it out as 64 beats of four bytes each, in the same index order the buffer is written. Sits between a tile buffer and any 4-byte-wide downstream consumer. Uses a valid/ready handshake with back-pressure, and signals completion with a last flag and a done pulse.

## Interface
- No parameters. Geometry is fixed: 16x16 bytes, 4 lanes, 64 beats.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- start  input  1  request a new stream; honoured only while the block is idle.
- in  input  8 x [0:15][0:15]  source matrix; sampled only on the cycle start is accepted.
- ready  input  1  downstream accepts the current beat.
- valid  output  1  out and index hold a beat.
- out  output  8 x [0:3]  four bytes of the current beat.
- index  output  6  beat number, 0..63.
- last  output  1  high with the beat where index = 63.
- busy  output  1  high from start acceptance until the final beat transfers.
- done  output  1  single-cycle pulse after the final beat.

## Operation
- States:
  - IDLE: valid=0, busy=0.
  - STREAM: valid=1, busy=1.
- IDLE -> STREAM: on start=1.
  - The whole of `in` is copied into an internal 16x16 snapshot.
  - index is set to 0.
- Beat mapping: row = index / 4, col = 4 * (index % 4); out[i] = snap[row][col + i] for i = 0..3.
- Transfer: valid && ready at a rising edge.
- In STREAM, a transfer with index < 63 increments index by 1.
- In STREAM, a transfer with index = 63:
  - returns the block to IDLE;
  - asserts done for the next cycle;
  - leaves index at 63.
- With ready=0, the state, index, out and last are held unchanged.
- start is ignored while in STREAM. The snapshot is not modified and the stream is not restarted.
- Changes on `in` after acceptance have no effect on the current stream.
- last = valid && (index == 63). It is combinational from the state and index.
- out is decoded combinationally from the snapshot and index. It is valid only while valid=1.
- Reset values:
  - state IDLE;
  - valid 0, busy 0, done 0, last 0;
  - index 0;
  - snapshot all zero, so out = 0.

## Timing
- Start latency: with start accepted at edge N, valid=1 and index=0 from edge N until the beat transfers.
- Throughput: with ready held at 1, a full stream takes 64 consecutive cycles (edges N+1 .. N+64).
  - done is high for the one cycle after the index-63 transfer.
- The done cycle is an IDLE cycle. A start asserted during it is accepted, so back-to-back streams have a one-cycle gap.
- Reset wins over every other input on the same edge. Reset mid-stream:
  - aborts the stream;
  - produces no done pulse;
  - leaves out = 0.
- start and reset together: reset wins and the start is dropped.
- A ready that toggles every cycle produces exactly 64 transfers with no duplicated or skipped index.

## Test plan
- Reset, then idle with no start -> valid=0, busy=0, done=0, index=0, all out bytes 0.
- Load in[r][c] = 16r + c, pulse start, hold ready=1:
  - index 5 beat -> out = 0x14,0x15,0x16,0x17;
  - index 63 beat -> out = 0xFC..0xFF with last=1;
  - done=1 exactly one cycle later;
  - 64 beats total.
- Same stream with ready alternating 1/0:
  - out and index are held while ready=0;
  - exactly 64 transfers, in order 0..63;
  - done only after index 63.
- After start, overwrite `in` with all 0xAA and pulse start again mid-stream -> the stream continues with the original 16r + c data and busy stays 1.
- Assert reset at index 30 -> the next cycle shows valid=0, busy=0, index=0, done never pulses. A following start streams the current `in` from index 0.
- Assert start during the done cycle -> the new stream begins: valid=1, index=0 on the following cycle.
